// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY link bring-up logic: FSM state
// encoding and the debug/status field widths reused by management registers.
package eth_phy_10g_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STATUS = 3'd3,
    ST_UP          = 3'd4,
    ST_FAULT       = 3'd5
  } link_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_phy_10g_link_ctrl_if.sv
// Link-control signal bundle: PHY RX status in, PHY resets and link state out.
interface eth_phy_10g_link_ctrl_if;
  import eth_phy_10g_pkg::*;

  logic               cfg_enable;
  logic               rx_block_lock;
  logic               rx_high_ber;
  logic               rx_status;
  logic               phy_rst;
  logic               serdes_rx_reset_req;
  logic               link_up;
  logic               link_fault;
  logic [RETRY_W-1:0] retry_count;
  logic [STATE_W-1:0] state;

  modport master (
    input  cfg_enable, rx_block_lock, rx_high_ber, rx_status,
    output phy_rst, serdes_rx_reset_req, link_up, link_fault, retry_count, state
  );

  modport slave (
    output cfg_enable, rx_block_lock, rx_high_ber, rx_status,
    input  phy_rst, serdes_rx_reset_req, link_up, link_fault, retry_count, state
  );

endinterface

// File: rtl/eth_phy_10g_link_timer.sv
// Loadable, clearable saturating up-counter with a terminal-count compare flag.
module eth_phy_10g_link_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] tc_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == tc_value);

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10GBASE-R RX link bring-up sequencer: resets PHY/SERDES, waits for block lock
// and RX status, retries on timeout and latches a fault after MAX_RETRIES.
module eth_phy_10g_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STATUS_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned DROP_CYCLES    = 8
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  eth_phy_10g_link_ctrl_if.master   link
);

  localparam int unsigned TIMER_W = $clog2(max_u(LOCK_TIMEOUT, STATUS_TIMEOUT));
  localparam int unsigned DROP_W  = $clog2(DROP_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TC_RESET  = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TC_LOCK   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TC_STATUS = TIMER_W'(STATUS_TIMEOUT - 1);
  localparam logic [DROP_W-1:0]  TC_DROP   = DROP_W'(DROP_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  link_state_e        state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               phy_rst_q, phy_rst_d;
  logic               serdes_q, serdes_d;
  logic               up_q, up_d;
  logic               fault_q, fault_d;
  logic               attempt_fail;

  logic [TIMER_W-1:0] timer_count, timer_tc_value;
  logic               timer_tc, timer_clr;
  logic [DROP_W-1:0]  drop_count;
  logic               drop_tc, drop_clr;

  // rx_high_ber influences the FSM only through rx_status; raw counts are debug-only.
  logic unused_sigs;
  assign unused_sigs = ^{timer_count, drop_count, link.rx_high_ber};

  always_comb begin
    timer_tc_value = '1;
    unique case (state_q)
      ST_RESET:       timer_tc_value = TC_RESET;
      ST_WAIT_LOCK:   timer_tc_value = TC_LOCK;
      ST_WAIT_STATUS: timer_tc_value = TC_STATUS;
      default:        timer_tc_value = '1;
    endcase
  end

  assign timer_clr = (state_d != state_q);
  assign drop_clr  = (state_q != ST_UP) || link.rx_status;

  eth_phy_10g_link_timer #(.WIDTH(TIMER_W)) u_state_timer (
    .clk        (rx_clk),
    .rst        (rx_rst),
    .clr        (timer_clr),
    .load       (1'b0),
    .load_value ('0),
    .inc        (1'b1),
    .tc_value   (timer_tc_value),
    .count      (timer_count),
    .tc         (timer_tc)
  );

  eth_phy_10g_link_timer #(.WIDTH(DROP_W)) u_drop_counter (
    .clk        (rx_clk),
    .rst        (rx_rst),
    .clr        (drop_clr),
    .load       (1'b0),
    .load_value ('0),
    .inc        (1'b1),
    .tc_value   (TC_DROP),
    .count      (drop_count),
    .tc         (drop_tc)
  );

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (link.cfg_enable) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (timer_tc) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (link.rx_block_lock) state_d = ST_WAIT_STATUS;
        else if (timer_tc)      attempt_fail = 1'b1;
      end
      ST_WAIT_STATUS: begin
        if (!link.rx_block_lock)  state_d = ST_WAIT_LOCK;
        else if (link.rx_status)  state_d = ST_UP;
        else if (timer_tc)        attempt_fail = 1'b1;
      end
      ST_UP: begin
        if (!link.rx_status && drop_tc) state_d = ST_RESET;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (attempt_fail) begin
      retry_d = retry_q + RETRY_W'(1);
      state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RESET;
    end

    if (!link.cfg_enable) state_d = ST_IDLE;

    // Clearing on the next state keeps retry_count aligned with the state it reports.
    if ((state_d == ST_IDLE) || (state_d == ST_UP)) retry_d = '0;

    phy_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAULT);
    serdes_d  = (state_d == ST_RESET);
    up_d      = (state_d == ST_UP);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      phy_rst_q <= 1'b1;
      serdes_q  <= 1'b0;
      up_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      phy_rst_q <= phy_rst_d;
      serdes_q  <= serdes_d;
      up_q      <= up_d;
      fault_q   <= fault_d;
    end
  end

  assign link.phy_rst             = phy_rst_q;
  assign link.serdes_rx_reset_req = serdes_q;
  assign link.link_up             = up_q;
  assign link.link_fault          = fault_q;
  assign link.retry_count         = retry_q;
  assign link.state               = state_q;

endmodule
